// File: rtl/ibuf_pkg.sv
// Shared types for the instruction line buffer: per-entry record and slot geometry.
package ibuf_pkg;
    localparam int IBUF_SLOTS  = 4;
    localparam int IBUF_SLOT_W = 32;
    localparam int IBUF_PC_W   = 48;

    typedef struct packed {
        logic [IBUF_SLOT_W-1:0] inst;
        logic [IBUF_PC_W-1:0]   pc;
        logic                   predtaken;
        logic [31:0]            predtarget;
    } ibuf_entry_t;
endpackage

// File: rtl/ibuf_slot_select.sv
// Which slots of a fetch line are live: from the first addressed slot up to the
// predicted-taken branch (or the end of the line).
module ibuf_slot_select
    import ibuf_pkg::*;
(
    input  logic [1:0]            first_slot,
    input  logic                  predtaken,
    input  logic [1:0]            predslot,
    output logic [IBUF_SLOTS-1:0] slot_mask,
    output logic [2:0]            n
);
    logic [1:0] last_slot;

    always_comb begin
        last_slot = predtaken ? predslot : 2'd3;
        slot_mask = '0;
        n         = '0;
        // A prediction ahead of the entry point leaves nothing to enqueue.
        if (last_slot >= first_slot) begin
            n = {1'b0, last_slot} - {1'b0, first_slot} + 3'd1;
            for (int k = 0; k < IBUF_SLOTS; k++)
                slot_mask[k] = (2'(k) >= first_slot) && (2'(k) <= last_slot);
        end
    end
endmodule

// File: rtl/inst_line_buffer.sv
// Circular instruction FIFO between fetch line return and decode: up to four
// pushes per line, one pop per cycle, single-cycle flush.
module inst_line_buffer
    import ibuf_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PC_WIDTH = IBUF_PC_W   // must not exceed IBUF_PC_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       line_valid,
    output logic                       line_ready,
    input  logic [127:0]               line_data,
    input  logic [PC_WIDTH-1:0]        line_pc,
    input  logic                       line_predtaken,
    input  logic [1:0]                 line_predslot,
    input  logic [31:0]                line_predtarget,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_inst,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic                       out_predtaken,
    output logic [31:0]                out_predtarget,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ibuf_entry_t            mem [DEPTH];
    logic [PW-1:0]          rd_ptr, wr_ptr;
    logic [CW-1:0]          count_q;
    logic [IBUF_SLOTS-1:0]  slot_mask;
    logic [2:0]             n;
    logic                   push, pop;
    ibuf_entry_t            slot_ent [IBUF_SLOTS];
    logic [PW-1:0]          slot_idx [IBUF_SLOTS];
    logic [1:0]             unused_pc_lsb;

    assign unused_pc_lsb = line_pc[1:0];

    ibuf_slot_select u_sel (
        .first_slot (line_pc[3:2]),
        .predtaken  (line_predtaken),
        .predslot   (line_predslot),
        .slot_mask  (slot_mask),
        .n          (n)
    );

    assign count      = count_q;
    assign line_ready = (count_q <= CW'(DEPTH - IBUF_SLOTS));
    assign out_valid  = (count_q != '0);
    assign push       = line_valid & line_ready & ~flush;
    assign pop        = out_valid & out_ready & ~flush;

    // Live slots are contiguous from first_slot, so slot k lands k-first past wr_ptr.
    for (genvar k = 0; k < IBUF_SLOTS; k++) begin : g_slot
        assign slot_ent[k].inst       = line_data[IBUF_SLOT_W*k +: IBUF_SLOT_W];
        assign slot_ent[k].pc         = IBUF_PC_W'({line_pc[PC_WIDTH-1:4], 2'(k), 2'b00});
        assign slot_ent[k].predtaken  = line_predtaken && (line_predslot == 2'(k));
        assign slot_ent[k].predtarget = slot_ent[k].predtaken ? line_predtarget : 32'd0;
        assign slot_idx[k]            = wr_ptr + PW'(2'(k) - line_pc[3:2]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            for (int k = 0; k < IBUF_SLOTS; k++)
                if (push && slot_mask[k]) mem[slot_idx[k]] <= slot_ent[k];
            if (push) wr_ptr <= wr_ptr + PW'(n);
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + (push ? CW'(n) : '0) - (pop ? CW'(1) : '0);
        end
    end

    assign out_inst       = mem[rd_ptr].inst;
    assign out_pc         = mem[rd_ptr].pc[PC_WIDTH-1:0];
    assign out_predtaken  = mem[rd_ptr].predtaken;
    assign out_predtarget = mem[rd_ptr].predtarget;
endmodule

// File: tb/tb_inst_line_buffer.sv
// Scoreboard bench for inst_line_buffer: directed scenarios then random traffic
// against a queue-based reference model.
module tb_inst_line_buffer;
    localparam int DEPTH = 16;
    localparam int PCW   = 48;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         line_valid = 1'b0;
    logic         line_ready;
    logic [127:0] line_data = '0;
    logic [PCW-1:0] line_pc = '0;
    logic         line_predtaken = 1'b0;
    logic [1:0]   line_predslot = '0;
    logic [31:0]  line_predtarget = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_inst;
    logic [PCW-1:0] out_pc;
    logic         out_predtaken;
    logic [31:0]  out_predtarget;
    logic [4:0]   count;

    inst_line_buffer #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
        .line_pc(line_pc), .line_predtaken(line_predtaken), .line_predslot(line_predslot),
        .line_predtarget(line_predtarget), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_predtaken(out_predtaken),
        .out_predtarget(out_predtarget), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0]    inst;
        logic [PCW-1:0] pc;
        bit             pt;
        logic [31:0]    tgt;
    } exp_t;

    exp_t q[$];
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    bit   mon_en = 0;
    bit   rdy_exp = 1;

    // next line to present, and what was presented last cycle
    logic [127:0]   n_data;
    logic [PCW-1:0] n_pc;
    bit             n_pt;
    logic [1:0]     n_ps;
    logic [31:0]    n_tgt;
    logic [127:0]   p_data;
    logic [PCW-1:0] p_pc;
    bit             p_pt, p_push, p_fl, p_rs = 1;
    logic [1:0]     p_ps;
    logic [31:0]    p_tgt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: enqueue slots first..last of a line in ascending order.
    task automatic model_push(input logic [127:0] d, input logic [PCW-1:0] pc,
                              input bit pt, input logic [1:0] ps, input logic [31:0] tgt);
        int first, last;
        exp_t e;
        first = int'(pc[3:2]);
        last  = pt ? int'(ps) : 3;
        for (int k = first; k <= last; k++) begin
            e.inst = d[32*k +: 32];
            e.pc   = {pc[PCW-1:4], 4'b0000} + PCW'(4 * k);
            e.pt   = pt && (k == int'(ps));
            e.tgt  = e.pt ? tgt : 32'd0;
            q.push_back(e);
        end
    endtask

    task automatic set_line(input logic [PCW-1:0] pc, input logic [127:0] d,
                            input bit pt, input logic [1:0] ps, input logic [31:0] tgt);
        n_pc = pc; n_data = d; n_pt = pt; n_ps = ps; n_tgt = tgt;
    endtask

    task automatic step(input bit v, input bit ordy, input bit fl, input bit rs, output bit acc);
        @(posedge clock); #1;
        if (p_rs || p_fl) q.delete();
        else if (p_push) model_push(p_data, p_pc, p_pt, p_ps, p_tgt);
        rdy_exp = (DEPTH - q.size()) >= 4;
        line_valid = v; out_ready = ordy; flush = fl; reset = rs;
        line_pc = n_pc; line_data = n_data; line_predtaken = n_pt;
        line_predslot = n_ps; line_predtarget = n_tgt;
        acc = v && rdy_exp && !fl && !rs;
        p_push = acc; p_fl = fl; p_rs = rs;
        p_pc = n_pc; p_data = n_data; p_pt = n_pt; p_ps = n_ps; p_tgt = n_tgt;
    endtask

    task automatic send_line(input bit ordy);
        bit acc;
        int tries = 0;
        do begin
            step(1, ordy, 0, 0, acc);
            tries++;
        end while (!acc && tries < 64);
        check("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int cycles, input bit ordy);
        bit acc;
        for (int i = 0; i < cycles; i++) step(0, ordy, 0, 0, acc);
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 40 && (q.size() != 0 || p_push); i++) step(0, 1, 0, 0, acc);
        step(0, 0, 0, 0, acc);
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Monitor: mid-cycle compare of status and, on a pop, the head entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                check("count", 64'(count), 64'(q.size()));
                check("line_ready", 64'(line_ready), 64'(rdy_exp));
                check("out_valid", 64'(out_valid), 64'(q.size() != 0));
                if (q.size() != 0 && out_ready && !flush && !reset) begin
                    e = q.pop_front();
                    check("out_inst", 64'(out_inst), 64'(e.inst));
                    check("out_pc", 64'(out_pc), 64'(e.pc));
                    check("out_predtaken", 64'(out_predtaken), 64'(e.pt));
                    check("out_predtarget", 64'(out_predtarget), 64'(e.tgt));
                end
            end
        end
    end

    initial begin
        bit acc;
        set_line('0, '0, 0, 0, 0);
        step(0, 0, 0, 1, acc);
        step(0, 0, 0, 0, acc);
        mon_en = 1;
        @(negedge clock); #1;
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_predtaken", 64'(out_predtaken), 64'd0);
        check("rst_out_predtarget", 64'(out_predtarget), 64'd0);

        // full aligned line
        set_line(48'h80000000, {32'h00400093, 32'h00300093, 32'h00200093, 32'h00100093}, 0, 0, 0);
        send_line(0);
        idle(1, 0);
        drain();

        // unaligned start: slots 2,3 only
        set_line(48'h80000008, {32'h00400093, 32'h00300093, 32'h00200093, 32'h00100093}, 0, 0, 0);
        send_line(0);
        idle(1, 0);
        drain();

        // truncation at predicted-taken slot 1
        set_line(48'h80000000, {32'hdddd0004, 32'hcccc0003, 32'hbbbb0002, 32'haaaa0001}, 1, 2'd1, 32'h80001000);
        send_line(0);
        idle(1, 0);
        drain();

        // prediction before entry point: line consumed, nothing stored
        set_line(48'h8000000C, {4{32'h12345678}}, 1, 2'd1, 32'h1);
        send_line(0);
        idle(2, 0);

        // fill to DEPTH, hold a line while full, then pop with it held
        for (int i = 0; i < 4; i++) begin
            set_line(48'h80000100 + 48'(16 * i), {32'(4*i+3), 32'(4*i+2), 32'(4*i+1), 32'(4*i)}, 0, 0, 0);
            send_line(0);
        end
        set_line(48'h80000140, {32'h13, 32'h12, 32'h11, 32'h10}, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, acc);
        check("full_not_accepted", 64'(acc), 64'd0);
        send_line(1);
        drain();

        // flush races push and pop with six entries resident
        set_line(48'h80000200, {32'h23, 32'h22, 32'h21, 32'h20}, 0, 0, 0);
        send_line(0);
        set_line(48'h80000218, {32'h33, 32'h32, 32'h31, 32'h30}, 0, 0, 0);
        send_line(0);
        set_line(48'h80000300, {32'h43, 32'h42, 32'h41, 32'h40}, 0, 0, 0);
        step(1, 1, 1, 0, acc);
        step(0, 0, 0, 0, acc);
        set_line(48'h80002000, {32'h53, 32'h52, 32'h51, 32'h50}, 0, 0, 0);
        send_line(0);
        idle(1, 0);
        drain();

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            set_line({16'($urandom()), 32'($urandom())},
                     {32'($urandom()), 32'($urandom()), 32'($urandom()), 32'($urandom())},
                     ($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)), 32'($urandom()));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 999) < 3, acc);
        end
        drain();

        mon_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
